// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped one-word-per-line instruction cache controller
//
// Sits between instruction fetch and the fetch port of the byte-serial memory
// controller. Hits are answered one cycle after the request. A miss issues one
// 4-byte fetch on mem_need/mem_addr, waits for the mem_ready pulse, installs the
// returned word and forwards it unless a flush arrived in the meantime.
//
// Ports:
//   clk_in     system clock
//   rst_in     synchronous active-low reset
//   rdy_in     global ready; low freezes every register
//   clear_in   pipeline flush; cancels the response of an outstanding miss
//   if_req     fetch request level
//   if_pc      fetch address (word aligned)
//   if_ready   single-cycle pulse, if_ins valid
//   if_ins     fetched instruction
//   mem_need   fetch request to the memory controller (iCache_need)
//   mem_addr   fetch address to the memory controller (ins_addr)
//   mem_ready  fetch-complete pulse from the memory controller (ins_ready)
//   mem_ins    fetched word from the memory controller (ins)
//   hit_cnt    accepted hits, wraps   (only with ICACHE_PERF_EN)
//   miss_cnt   misses issued, wraps   (only with ICACHE_PERF_EN)
//
// Optional feature macro: ICACHE_PERF_EN adds the hit_cnt/miss_cnt counters.

module icache_ctrl #(
    parameter int IDX_W = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic        if_req,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic [31:0] if_ins,
    output logic        mem_need,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_ins
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int TAG_W = 32 - IDX_W - 2;
    localparam int LINES = 1 << IDX_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               if_ready_q, if_ready_d;
    logic [31:0]        if_ins_q, if_ins_d;
    logic               mem_need_q, mem_need_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [IDX_W-1:0]   miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
    logic               cancel_q, cancel_d;
    logic [LINES-1:0]   valid_q, valid_d;

    // Tag and data arrays carry no reset; only the valid bits do.
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES];

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               hit;
    logic               hit_acc;
    logic               miss_acc;
    logic               fill_we;

    assign req_idx = if_pc[IDX_W+1:2];
    assign req_tag = if_pc[31:IDX_W+2];
    assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    always_comb begin
        state_d    = state_q;
        if_ready_d = 1'b0;
        if_ins_d   = if_ins_q;
        mem_need_d = mem_need_q;
        mem_addr_d = mem_addr_q;
        miss_idx_d = miss_idx_q;
        miss_tag_d = miss_tag_q;
        cancel_d   = cancel_q;
        valid_d    = valid_q;
        fill_we    = 1'b0;
        hit_acc    = 1'b0;
        miss_acc   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A request seen while the previous answer is still on
                // if_ready belongs to the old pc, so it is ignored.
                if (!clear_in && if_req && !if_ready_q) begin
                    if (hit) begin
                        hit_acc    = 1'b1;
                        if_ready_d = 1'b1;
                        if_ins_d   = data_q[req_idx];
                    end else begin
                        miss_acc   = 1'b1;
                        mem_need_d = 1'b1;
                        mem_addr_d = if_pc;
                        miss_idx_d = req_idx;
                        miss_tag_d = req_tag;
                        cancel_d   = 1'b0;
                        state_d    = S_MISS;
                    end
                end
            end

            S_MISS: begin
                // The memory controller cannot abort a fetch, so a flush only
                // marks the response as unwanted; the fill still completes.
                if (clear_in) begin
                    cancel_d = 1'b1;
                end
                if (mem_ready) begin
                    fill_we             = 1'b1;
                    valid_d[miss_idx_q] = 1'b1;
                    mem_need_d          = 1'b0;
                    mem_addr_d          = 32'd0;
                    cancel_d            = 1'b0;
                    state_d             = S_IDLE;
                    if (!cancel_q && !clear_in) begin
                        if_ready_d = 1'b1;
                        if_ins_d   = mem_ins;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            if_ready_q <= 1'b0;
            if_ins_q   <= 32'd0;
            mem_need_q <= 1'b0;
            mem_addr_q <= 32'd0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            cancel_q   <= 1'b0;
            valid_q    <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            if_ready_q <= if_ready_d;
            if_ins_q   <= if_ins_d;
            mem_need_q <= mem_need_d;
            mem_addr_q <= mem_addr_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
            cancel_q   <= cancel_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && fill_we) begin
            tag_q[miss_idx_q]  <= miss_tag_q;
            data_q[miss_idx_q] <= mem_ins;
        end
    end

    assign if_ready = if_ready_q;
    assign if_ins   = if_ins_q;
    assign mem_need = mem_need_q;
    assign mem_addr = mem_addr_q;

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + {31'd0, hit_acc};
        miss_cnt_d = miss_cnt_q + {31'd0, miss_acc};
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else if (rdy_in) begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
